// File: rtl/mem_bridge.sv
// mem_bridge: bridges the 16-bit core memory port onto a byte-wide external
// bus with an acknowledge handshake. Halfwords are split into two
// little-endian byte beats. A per-beat timeout turns a missing acknowledge
// into an error completion.
//
// Optional feature: define MEM_BRIDGE_MISALIGN_TRAP_EN to trap halfword
// requests with addr[0]=1 (no bus beat, error completion). When it is left
// undefined, addr[0] is ignored for halfwords and the access proceeds.
module mem_bridge #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        byte_half,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        bus_en,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The counter only has to reach TIMEOUT, which never exceeds 255.
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] addr_q,  addr_d;
    logic        we_q,    we_d;
    logic        half_q,  half_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    // State and latched request registers; reset drops any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            half_q  <= 1'b0;
            wdata_q <= 16'h0000;
            cnt_q   <= 8'h00;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            half_q  <= half_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: request capture, beat sequencing, data capture, timeout.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        half_d  = half_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    half_d  = byte_half;
                    wdata_d = wdata;
                    cnt_d   = 8'h00;
                    err_d   = 1'b0;
`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
                    if (byte_half && addr[0]) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_BEAT0;
                    end
`else
                    state_d = ST_BEAT0;
`endif
                end
            end

            ST_BEAT0: begin
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d[7:0] = bus_rdata;
                        if (!half_q) begin
                            rdata_d[15:8] = 8'h00;
                        end
                    end
                    if (half_q) begin
                        state_d = ST_BEAT1;
                        cnt_d   = 8'h00;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = 16'hFFFF;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_BEAT1: begin
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d[15:8] = bus_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = 16'hFFFF;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and latched fields only, never from req.
    always_comb begin
        done      = 1'b0;
        err       = 1'b0;
        busy      = (state_q != ST_IDLE);
        bus_en    = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        rdata     = rdata_q;

        case (state_q)
            ST_BEAT0: begin
                bus_en    = 1'b1;
                bus_we    = we_q;
                bus_addr  = half_q ? {addr_q[15:1], 1'b0} : addr_q;
                bus_wdata = wdata_q[7:0];
            end
            ST_BEAT1: begin
                bus_en    = 1'b1;
                bus_we    = we_q;
                bus_addr  = {addr_q[15:1], 1'b1};
                bus_wdata = wdata_q[15:8];
            end
            ST_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Bridges the 16-bit core memory port (instruction fetch, loads, stores) onto a byte-wide external SRAM/peripheral bus with an acknowledge handshake. It sits directly downstream of the control unit: it takes the control unit's address, write data, write enable and byte/halfword select, and returns read data and completion. Halfword accesses split into two little-endian byte beats. A timeout counter converts a missing acknowledge into an error completion.

## Interface
- `TIMEOUT`, default 15: cycles without `bus_ack` in one beat before the access aborts; legal range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request, level-sensitive; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load/fetch.
- `byte_half`  in  1  1 = 16-bit halfword, 0 = byte; same encoding as the control unit's `mem_byte_half`.
- `addr`  in  16  byte address.
- `wdata`  in  16  store data; byte stores use `[7:0]`.
- `rdata`  out  16  load data; held until the next accepted request.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = timeout or trapped misalignment.
- `busy`  out  1  high whenever the state is not IDLE.
- `bus_en`  out  1  beat active.
- `bus_we`  out  1  beat is a write.
- `bus_addr`  out  16  beat byte address.
- `bus_wdata`  out  8  beat write byte.
- `bus_rdata`  in  8  beat read byte; sampled on ack.
- `bus_ack`  in  1  beat completes in any cycle where `bus_en & bus_ack`.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE with `req=1`:
  - Latch `addr`, `we`, `byte_half`, `wdata`, and clear the timeout counter.
  - Go to BEAT0.
  - A misaligned halfword under the trap option goes to DONE with an error instead (see Configuration).
- BEAT0:
  - `bus_en=1`, `bus_we=we`.
  - `bus_addr` is the latched addr, with bit 0 forced to 0 for halfwords.
  - `bus_wdata` is `wdata[7:0]`.
  - On ack:
    - A load captures `bus_rdata` into `rdata[7:0]`.
    - A byte load also clears `rdata[15:8]` (zero-extend).
    - A byte access then goes to DONE; a halfword goes to BEAT1 with the counter cleared.
- BEAT1:
  - `bus_addr = {addr[15:1],1'b1}`, `bus_wdata = wdata[15:8]`.
  - On ack, a load captures `rdata[15:8]`; the state goes to DONE.
- Timeout in BEAT0/BEAT1:
  - The counter increments every cycle without ack.
  - When the counter equals TIMEOUT and there is still no ack, the state goes to DONE with `err=1`.
  - `rdata` is set to 16'hFFFF for loads; partially written bytes of a store stay written.
- DONE: `done=1`, `err` per the result, `bus_en=0`; the next state is unconditionally IDLE.
- `req` is ignored outside IDLE. The upstream drops `req` in the `done` cycle; if `req` is still high in the following IDLE cycle, a new access starts.
- Ack in the same cycle the counter reaches TIMEOUT: the ack wins and there is no error.
- Bus signals (`bus_en`, `bus_we`, `bus_addr`, `bus_wdata`) are registered or decoded from the state only; there is no combinational path from `req` to `bus_*`.

## Timing
- Reset (asynchronous, any state, including mid-beat):
  - State goes to IDLE.
  - `done`, `err`, `busy`, `bus_en`, `bus_we` = 0.
  - `bus_addr`, `bus_wdata`, `rdata` = 0.
  - The counter is cleared; an in-flight beat is dropped.
- Latency with zero-wait ack, request accepted at edge N:
  - Byte: BEAT0 in cycle N+1, `done` in cycle N+2.
  - Halfword: BEAT0 in N+1, BEAT1 in N+2, `done` in N+3.
- Each wait cycle (ack low) adds one cycle to its beat.
- Timeout error: `done` arrives TIMEOUT+1 cycles after that beat started.
- `busy` rises in the cycle after acceptance and falls after the `done` cycle.

## Configuration
- `MEM_BRIDGE_MISALIGN_TRAP_EN` defined: a halfword request with `addr[0]=1` issues no beat. The next cycle is DONE with `err=1`, and `rdata` is unchanged.
- Not defined: `addr[0]` is ignored for halfwords (forced even). The access proceeds normally and `err` can only come from timeout.

## Test plan
- Halfword load at 0x0010, ack always 1, bus returns 0x34 then 0x12:
  - `bus_addr` is 0x0010 then 0x0011.
  - `done` arrives 3 cycles after acceptance with `rdata=0x1234`, `err=0`.
- Byte load at 0x0021 returning 0xAB with 2 wait cycles: a single beat at 0x0021, `done` 4 cycles after acceptance, `rdata=0x00AB`.
- Halfword store of 0xBEEF at 0x0040: beats write 0xEF@0x0040 then 0xBE@0x0041 with `bus_we=1`; `done=1`, `err=0`.
- Load with `bus_ack` held 0, TIMEOUT=15: `done` with `err=1` and `rdata=0xFFFF` 16 cycles after BEAT0 starts. With ack asserted exactly on the 15th wait cycle, the access completes with no error.
- Halfword at 0x0003:
  - With the macro: no `bus_en`, `done`+`err` one cycle later.
  - Without the macro: beats at 0x0002 and 0x0003, `err=0`.
- `rst_n` pulsed low during BEAT1 of a halfword load:
  - Outputs are zero immediately and the state is IDLE.
  - A subsequent request completes normally.
